itu_656_encoder: RTL and testbench
==================================

ITU_656_ENCODER -- requirements
Module: itu_656_encoder

Interface
REQ-001 Parameter: H_BLANK, 268, blanking bytes between EAV and SAV per line.
REQ-002 Parameter: H_ACTIVE, 1440, active bytes per line (720 pixels, C/Y interleaved).
REQ-003 Port: iCLK_27  input  1  single byte clock, 27 MHz; all logic on rising edge.
REQ-004 Port: iRST  input  1  reset, asynchronous, active-high.
REQ-005 Port: iYCbCr  input  16  pixel word: [15:8] Y, [7:0] Cb (even pixel) or Cr (odd pixel).
REQ-006 Port: iEN  input  1  1 = send pixel data; 0 = send blanking level in active region.
REQ-007 Port: oTD_DATA  output  8  registered ITU-R 656 byte stream.
REQ-008 Port: oRequest  output  1  one-cycle pixel request, read latency 1.
REQ-009 Port: oPixel_X  output  10  pixel index 0..719 of the current request.
REQ-010 Port: oLine  output  10  current line number 1..525.
REQ-011 Port: oField  output  1  F bit of current line.
REQ-012 Port: oVBlank  output  1  V bit of current line.

Function
REQ-013 Byte counter h_cnt SHALL run 0..(8+H_BLANK+H_ACTIVE-1) = 0..1715, wrapping to 0.
REQ-014 Regions: h_cnt 0-3 EAV, 4-271 blanking, 272-275 SAV, 276-1715 active.
REQ-015 Line counter SHALL increment when h_cnt wraps; 525 wraps to 1.
REQ-016 F SHALL be 0 for lines 4-265 and 1 otherwise; V SHALL be 1 for lines 1-19 and 264-282 and 0 otherwise.
REQ-017 EAV/SAV SHALL be FF,00,00,XY; XY = {1,F,V,H,V^H,F^H,F^V,F^V^H}; H=1 for EAV, 0 for SAV.
REQ-018 Blanking bytes, and active bytes when V=1 or when iEN=0, SHALL alternate 0x80 (even offset from region start), 0x10 (odd offset).
REQ-019 oTD_DATA SHALL present the byte for position h_cnt=n in the cycle where h_cnt=n+1 (one register stage), including across line wrap.
REQ-020 oRequest SHALL be 1 exactly when V=0 and h_cnt is even in 274..1712; else 0; 720 requests per active line, none on V=1 lines.
REQ-021 oPixel_X SHALL equal (h_cnt-274)/2 while oRequest=1, and hold its last value otherwise.
REQ-022 iYCbCr SHALL be captured in the cycle after oRequest; its C byte SHALL appear on oTD_DATA two cycles after capture, its Y byte three cycles after.
REQ-023 Active data bytes SHALL be clamped: 0x00 -> 0x01, 0xFF -> 0xFE; 0x01..0xFE pass unchanged.
REQ-024 iEN SHALL be sampled per pixel at capture time; a mid-line change affects only subsequent pixels, never splitting a C/Y pair.
REQ-025 oLine, oField, oVBlank SHALL change in the same cycle the line counter changes (h_cnt=0).

Reset
REQ-026 While iRST=1: h_cnt=0, line=1, oTD_DATA=0x00, oRequest=0, oPixel_X=0, capture register=0x1080.
REQ-027 oLine=1, oField=1, oVBlank=1 during reset (values for line 1).
REQ-028 Reset asserted mid-line SHALL take effect immediately, asynchronously; first cycle after release has h_cnt=0 and next cycle oTD_DATA=0xFF (line 1 EAV).

Verification
REQ-029 Release reset, iEN=0 -> line 1: EAV FF 00 00 F1, 268 bytes 80/10, SAV FF 00 00 EC, 1440 bytes 80/10; no oRequest.
REQ-030 Run to line 20 -> EAV XY=0x9D, SAV XY=0x80; 720 oRequest pulses, first at h_cnt=274 with oPixel_X=0, last at 1712 with oPixel_X=719.
REQ-031 Line 300, iEN=1, iYCbCr={Y=0x40,C=0x90} for all pixels -> EAV XY=0xDA, SAV XY=0xC7; active bytes 90 40 repeating, first 0x90 in cycle h_cnt=277.
REQ-032 iYCbCr=0xFF00 on pixel 0, 0x00FF on pixel 1 -> active bytes 01 FE FE 01.
REQ-033 Count one full frame -> 525 lines, 1716 bytes each, 487 lines with requests, line 525 wraps to 1, oField toggles at lines 4 and 266.
REQ-034 Assert iRST at line 150 h_cnt=900 for 3 cycles -> outputs reset immediately; restart at line 1 with FF 00 00 F1.

Source files
------------

// File: rtl/itu_656_encoder_if.sv
// itu_656_encoder_if: pixel fetch and BT.656 byte-stream signals of the encoder.
// The master side is the encoder; the slave side is the pixel source / stream sink.
interface itu_656_if;
    logic [15:0] iYCbCr;
    logic        iEN;
    logic [7:0]  oTD_DATA;
    logic        oRequest;
    logic [9:0]  oPixel_X;
    logic [9:0]  oLine;
    logic        oField;
    logic        oVBlank;

    modport master (
        input  iYCbCr, iEN,
        output oTD_DATA, oRequest, oPixel_X, oLine, oField, oVBlank
    );

    modport slave (
        output iYCbCr, iEN,
        input  oTD_DATA, oRequest, oPixel_X, oLine, oField, oVBlank
    );
endinterface

// File: rtl/itu_656_encoder.sv
// itu_656_encoder: 525-line ITU-R BT.656 byte stream generator with EAV/SAV codes,
// blanking levels, per-pixel fetch requests and clamped active video.
module itu_656_encoder #(
    parameter int H_BLANK  = 268,
    parameter int H_ACTIVE = 1440
) (
    input logic      iCLK_27,
    input logic      iRST,
    itu_656_if.master bus
);
    localparam logic [10:0] H_LAST    = 11'(8 + H_BLANK + H_ACTIVE - 1);
    localparam logic [10:0] SAV_POS   = 11'(4 + H_BLANK);
    localparam logic [10:0] ACT_POS   = 11'(8 + H_BLANK);
    localparam logic [10:0] REQ_FIRST = 11'(6 + H_BLANK);
    localparam logic [10:0] REQ_LAST  = 11'(8 + H_BLANK + H_ACTIVE - 4);

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  line_q, line_d, px_q, px_d;
    logic [7:0]  td_q, td_d, blank, act_byte;
    logic [15:0] cap_q, cap_d;
    logic        en_q, en_d, req_q, req_d, req_dly_q, req_dly_d;
    logic        f, v, v_nxt;

    function automatic logic field_of(logic [9:0] l);
        return !(l >= 10'd4 && l <= 10'd265);
    endfunction

    function automatic logic vblank_of(logic [9:0] l);
        return l <= 10'd19 || (l >= 10'd264 && l <= 10'd282);
    endfunction

    function automatic logic [7:0] xy(logic ff, logic vv, logic hh);
        return {1'b1, ff, vv, hh, vv ^ hh, ff ^ hh, ff ^ vv, ff ^ vv ^ hh};
    endfunction

    function automatic logic [7:0] clamp(logic [7:0] b);
        return b == 8'h00 ? 8'h01 : b == 8'hFF ? 8'hFE : b;
    endfunction

    always_comb begin
        f = field_of(line_q);
        v = vblank_of(line_q);
        h_cnt_d = h_cnt_q == H_LAST ? 11'd0 : h_cnt_q + 11'd1;
        line_d = h_cnt_q != H_LAST ? line_q : line_q == 10'd525 ? 10'd1 : line_q + 10'd1;
        v_nxt = vblank_of(line_d);
        // Request is decided one cycle ahead so oRequest/oPixel_X come straight from flops
        req_d = !v_nxt && !h_cnt_d[0] && h_cnt_d >= REQ_FIRST && h_cnt_d <= REQ_LAST;
        px_d = req_d ? 10'((h_cnt_d - REQ_FIRST) >> 1) : px_q;
        req_dly_d = req_q;
        cap_d = req_dly_q ? bus.iYCbCr : cap_q;
        en_d = req_dly_q ? bus.iEN : en_q;
        blank = h_cnt_q[0] ? 8'h10 : 8'h80;
        act_byte = (v || !en_q) ? blank : clamp(h_cnt_q[0] ? cap_q[15:8] : cap_q[7:0]);
        td_d = h_cnt_q < 11'd4 ? (h_cnt_q == 11'd0 ? 8'hFF : h_cnt_q == 11'd3 ? xy(f, v, 1'b1) : 8'h00)
             : h_cnt_q < SAV_POS ? blank
             : h_cnt_q < ACT_POS ? (h_cnt_q == SAV_POS ? 8'hFF : h_cnt_q == SAV_POS + 11'd3 ? xy(f, v, 1'b0) : 8'h00)
             : act_byte;
    end

    always_ff @(posedge iCLK_27 or posedge iRST) begin
        if (iRST) begin
            h_cnt_q   <= '0;
            line_q    <= 10'd1;
            td_q      <= '0;
            req_q     <= 1'b0;
            req_dly_q <= 1'b0;
            px_q      <= '0;
            cap_q     <= 16'h1080;
            en_q      <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            line_q    <= line_d;
            td_q      <= td_d;
            req_q     <= req_d;
            req_dly_q <= req_dly_d;
            px_q      <= px_d;
            cap_q     <= cap_d;
            en_q      <= en_d;
        end
    end

    assign bus.oTD_DATA = td_q;
    assign bus.oRequest = req_q;
    assign bus.oPixel_X = px_q;
    assign bus.oLine    = line_q;
    assign bus.oField   = f;
    assign bus.oVBlank  = v;
endmodule

// File: tb/tb_itu_656_encoder.sv
// tb_itu_656_encoder: checks a full-size encoder over its first 21 lines and a
// narrow-line encoder over a whole frame plus a mid-line asynchronous reset.
module tb_itu_656_encoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int         inst;
        int         line;
        int         h;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[$];

    function automatic void chk(string nm, int inst, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (inst %0d): got 'h%0h, expected 'h%0h", nm, inst, act, exp);
        end
    endfunction

    function automatic void chk_reset(int inst, logic [7:0] td, logic rq, logic [9:0] px,
                                      logic [9:0] ln, logic fl, logic vb);
        chk("rst_td", inst, td, 0);
        chk("rst_req", inst, rq, 0);
        chk("rst_px", inst, px, 0);
        chk("rst_line", inst, ln, 1);
        chk("rst_field", inst, fl, 1);
        chk("rst_vblank", inst, vb, 1);
    endfunction

    function automatic bit f_of(int l);
        return !(l >= 4 && l <= 265);
    endfunction

    function automatic bit v_of(int l);
        return l <= 19 || (l >= 264 && l <= 282);
    endfunction

    function automatic logic [7:0] xy_of(bit f, bit v, bit h);
        logic [3:0] p;
        p = {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
        return {1'b1, f, v, h, p};
    endfunction

    function automatic logic [7:0] lim(logic [7:0] b);
        return b == 8'h00 ? 8'h01 : b == 8'hFF ? 8'hFE : b;
    endfunction

    function automatic logic [7:0] rnd_byte();
        int r;
        r = $urandom % 4;
        return r == 0 ? 8'h00 : r == 1 ? 8'hFF : 8'($urandom);
    endfunction

    // Byte the stream must carry at position h of line l; d/e is the pixel covering h.
    function automatic logic [7:0] exp_byte(int hb, int l, int h, logic [15:0] d, bit e);
        int sav = 4 + hb;
        int act = 8 + hb;
        bit f = f_of(l);
        bit v = v_of(l);
        if (h < 4) return h == 0 ? 8'hFF : h == 3 ? xy_of(f, v, 1'b1) : 8'h00;
        if (h >= sav && h < act) return h == sav ? 8'hFF : h == sav + 3 ? xy_of(f, v, 1'b0) : 8'h00;
        if (h < sav || v || !e) return ((h - (h < sav ? 4 : act)) % 2 == 0) ? 8'h80 : 8'h10;
        return lim(((h - act) % 2 == 0) ? d[7:0] : d[15:8]);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int HB  = (g == 0) ? 268 : 12;
        localparam int HA  = (g == 0) ? 1440 : 32;
        localparam int TOT = 8 + HB + HA;

        logic rst;
        itu_656_if bus();
        itu_656_encoder #(.H_BLANK(HB), .H_ACTIVE(HA)) dut (
            .iCLK_27(clk),
            .iRST   (rst),
            .bus    (bus)
        );

        bit fin = 1'b0;
        bit have_prev, frame_done, did_rst, last_f, rq, cap;
        int h, line, prev, px_exp, req_cnt, lines_req, line_chg, cyc, last_obs, max_line, k, kk;
        int tq[$];
        logic [7:0] pend;
        logic [15:0] d;
        bit e;
        logic [15:0] pd [720];
        bit pe [720];

        initial begin
            rst = 1'b1;
            bus.iYCbCr = 16'h0;
            bus.iEN = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk_reset(g, bus.oTD_DATA, bus.oRequest, bus.oPixel_X, bus.oLine, bus.oField, bus.oVBlank);
            rst = 1'b0;
            h = 0; line = 1; px_exp = 0; have_prev = 0; req_cnt = 0; lines_req = 0;
            line_chg = 0; cyc = 0; last_obs = 1; last_f = 1; max_line = 1;
            frame_done = 0; did_rst = 0;
            for (int c = 0; c < 40000 && !fin; c++) begin
                if (int'(bus.oLine) != last_obs) begin
                    chk("line_len", g, cyc, TOT);
                    line_chg++;
                    if (bus.oField != last_f) tq.push_back(int'(bus.oLine));
                    last_obs = int'(bus.oLine);
                    last_f = bus.oField;
                    cyc = 0;
                end
                cyc++;
                if (int'(bus.oLine) > max_line) max_line = int'(bus.oLine);
                rq = !v_of(line) && h % 2 == 0 && h >= 6 + HB && h <= TOT - 4;
                if (rq) begin
                    px_exp = (h - 6 - HB) / 2;
                    req_cnt++;
                end
                if (have_prev) chk("byte", g, bus.oTD_DATA, pend);
                chk("request", g, bus.oRequest, rq);
                chk("pixel_x", g, bus.oPixel_X, px_exp);
                chk("line", g, bus.oLine, line);
                chk("field", g, bus.oField, f_of(line));
                chk("vblank", g, bus.oVBlank, v_of(line));
                foreach (vecs[i])
                    if (have_prev && vecs[i].inst == g && vecs[i].line == line && vecs[i].h == h)
                        chk("vec_byte", g, bus.oTD_DATA, vecs[i].exp);
                cap = !v_of(line) && h % 2 == 1 && h >= 7 + HB && h <= TOT - 3;
                k = cap ? (h - 7 - HB) / 2 : 0;
                d = {rnd_byte(), rnd_byte()};
                e = ($urandom % 4) != 0;
                if (line == 300) begin
                    d = 16'h4090;
                    e = 1'b1;
                end
                if (line == 301 && cap && k < 2) begin
                    d = (k == 0) ? 16'hFF00 : 16'h00FF;
                    e = 1'b1;
                end
                bus.iYCbCr = d;
                bus.iEN = e;
                if (cap) begin
                    pd[k] = d;
                    pe[k] = e;
                end
                kk = (h >= 8 + HB) ? (h - 8 - HB) / 2 : 0;
                pend = exp_byte(HB, line, h, pd[kk], pe[kk]);
                have_prev = 1;
                @(posedge clk);
                #1;
                h = (h == TOT - 1) ? 0 : h + 1;
                if (h == 0) begin
                    prev = line;
                    line = (line == 525) ? 1 : line + 1;
                    chk("req_per_line", g, req_cnt, v_of(prev) ? 0 : HA / 2);
                    if (req_cnt > 0) lines_req++;
                    req_cnt = 0;
                end
                if (line == 1 && h == 1 && !frame_done && line_chg > 0) begin
                    frame_done = 1;
                    chk("frame_lines", g, line_chg, 525);
                    chk("frame_max_line", g, max_line, 525);
                    chk("frame_req_lines", g, lines_req, 487);
                    chk("field_toggles", g, tq.size(), 2);
                    if (tq.size() == 2) begin
                        chk("field_toggle0", g, tq[0], 4);
                        chk("field_toggle1", g, tq[1], 266);
                    end
                end
                if (frame_done && !did_rst && line == 150 && h == TOT / 2) begin
                    did_rst = 1;
                    rst = 1'b1;
                    #1;
                    chk_reset(g, bus.oTD_DATA, bus.oRequest, bus.oPixel_X, bus.oLine, bus.oField, bus.oVBlank);
                    repeat (3) @(posedge clk);
                    #1;
                    chk_reset(g, bus.oTD_DATA, bus.oRequest, bus.oPixel_X, bus.oLine, bus.oField, bus.oVBlank);
                    rst = 1'b0;
                    h = 0; line = 1; px_exp = 0; have_prev = 0; req_cnt = 0;
                    last_obs = 1; last_f = 1; cyc = 0;
                end
                fin = (did_rst && line == 4) || (HA == 1440 && line == 21);
            end
            if (!fin) chk("run_complete", g, 0, 1);
            fin = 1;
        end
    end

    initial begin
        vecs.push_back('{0, 1, 1, 8'hFF});
        vecs.push_back('{0, 1, 2, 8'h00});
        vecs.push_back('{0, 1, 3, 8'h00});
        vecs.push_back('{0, 1, 4, 8'hF1});
        vecs.push_back('{0, 1, 5, 8'h80});
        vecs.push_back('{0, 1, 6, 8'h10});
        vecs.push_back('{0, 1, 272, 8'h10});
        vecs.push_back('{0, 1, 273, 8'hFF});
        vecs.push_back('{0, 1, 276, 8'hEC});
        vecs.push_back('{0, 1, 277, 8'h80});
        vecs.push_back('{0, 1, 278, 8'h10});
        vecs.push_back('{0, 2, 0, 8'h10});
        vecs.push_back('{0, 20, 4, 8'h9D});
        vecs.push_back('{0, 20, 276, 8'h80});
        vecs.push_back('{1, 1, 4, 8'hF1});
        vecs.push_back('{1, 1, 20, 8'hEC});
        vecs.push_back('{1, 300, 4, 8'hDA});
        vecs.push_back('{1, 300, 20, 8'hC7});
        vecs.push_back('{1, 300, 21, 8'h90});
        vecs.push_back('{1, 300, 22, 8'h40});
        vecs.push_back('{1, 300, 23, 8'h90});
        vecs.push_back('{1, 301, 21, 8'h01});
        vecs.push_back('{1, 301, 22, 8'hFE});
        vecs.push_back('{1, 301, 23, 8'hFE});
        vecs.push_back('{1, 301, 24, 8'h01});
        for (int c = 0; c < 50000 && !(inst[0].fin && inst[1].fin); c++) @(posedge clk);
        if (!(inst[0].fin && inst[1].fin)) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got unfinished run, expected both instances done");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
